// File: rtl/rom_arbiter.sv
// Round-robin burst read controller sharing one 8x4 synchronous ROM between ports A and B.
// Define ROM_ARB_FIXED_PRIO_EN to make port A always win simultaneous requests.
module rom_arbiter (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       REQ_A,
  input  logic       REQ_B,
  input  logic [2:0] ADDR_A,
  input  logic [2:0] ADDR_B,
  input  logic [2:0] LEN_A,
  input  logic [2:0] LEN_B,
  output logic       GNT_A,
  output logic       GNT_B,
  output logic       VALID_A,
  output logic       VALID_B,
  output logic [3:0] DOUT_A,
  output logic [3:0] DOUT_B,
  output logic       DONE_A,
  output logic       DONE_B,
  output logic       BUSY,
  output logic [2:0] ROM_ADDR,
  input  logic [3:0] ROM_DATA
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_e;
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  state_e     state_q, state_d;
  port_e      owner_q, owner_d;
  port_e      last_q, last_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] addr_q, addr_d;
  logic       iss_q, iss_d;
  logic       gnt_a_q, gnt_a_d, gnt_b_q, gnt_b_d;
  logic       valid_a_q, valid_a_d, valid_b_q, valid_b_d;
  logic [3:0] dout_a_q, dout_a_d, dout_b_q, dout_b_d;
  logic       done_a_q, done_a_d, done_b_q, done_b_d;
  logic       busy_q, busy_d;
  logic       pick_a;

`ifdef ROM_ARB_FIXED_PRIO_EN
  assign pick_a = REQ_A;
`else
  // On a tie the port that did not own the previous burst wins.
  assign pick_a = REQ_A && (!REQ_B || (last_q == PORT_B));
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    iss_d     = 1'b0;
    gnt_a_d   = 1'b0;
    gnt_b_d   = 1'b0;
    busy_d    = (state_q != IDLE);
    valid_a_d = 1'b0;
    valid_b_d = 1'b0;
    dout_a_d  = 4'h0;
    dout_b_d  = 4'h0;
    done_a_d  = 1'b0;
    done_b_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (REQ_A || REQ_B) begin
          state_d = BURST;
          busy_d  = 1'b1;
          if (pick_a) begin
            gnt_a_d = 1'b1;
            addr_d  = ADDR_A;
            cnt_d   = LEN_A;
            owner_d = PORT_A;
            last_d  = PORT_A;
          end else begin
            gnt_b_d = 1'b1;
            addr_d  = ADDR_B;
            cnt_d   = LEN_B;
            owner_d = PORT_B;
            last_d  = PORT_B;
          end
        end
      end
      BURST: begin
        iss_d = 1'b1;
        if (cnt_q != 3'd0) begin
          addr_d = addr_q + 3'd1;
          cnt_d  = cnt_q - 3'd1;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        done_a_d = (owner_q == PORT_A);
        done_b_d = (owner_q == PORT_B);
      end
      default: state_d = IDLE;
    endcase

    // The ROM word addressed on the previous edge is captured one edge later.
    if (iss_q) begin
      if (owner_q == PORT_A) begin
        valid_a_d = 1'b1;
        dout_a_d  = ROM_DATA;
      end else begin
        valid_b_d = 1'b1;
        dout_b_d  = ROM_DATA;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      owner_q   <= PORT_A;
      last_q    <= PORT_B;
      cnt_q     <= 3'd0;
      addr_q    <= 3'd0;
      iss_q     <= 1'b0;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
      dout_a_q  <= 4'h0;
      dout_b_q  <= 4'h0;
      done_a_q  <= 1'b0;
      done_b_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      iss_q     <= iss_d;
      gnt_a_q   <= gnt_a_d;
      gnt_b_q   <= gnt_b_d;
      valid_a_q <= valid_a_d;
      valid_b_q <= valid_b_d;
      dout_a_q  <= dout_a_d;
      dout_b_q  <= dout_b_d;
      done_a_q  <= done_a_d;
      done_b_q  <= done_b_d;
      busy_q    <= busy_d;
    end
  end

  assign GNT_A    = gnt_a_q;
  assign GNT_B    = gnt_b_q;
  assign VALID_A  = valid_a_q;
  assign VALID_B  = valid_b_q;
  assign DOUT_A   = dout_a_q;
  assign DOUT_B   = dout_b_q;
  assign DONE_A   = done_a_q;
  assign DONE_B   = done_b_q;
  assign BUSY     = busy_q;
  assign ROM_ADDR = addr_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a behavioural 8x4 synchronous ROM (A,B,E,A,8,F,C,9).
module tb_rom_arbiter;

`ifdef ROM_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       REQ_A, REQ_B;
  logic [2:0] ADDR_A, ADDR_B, LEN_A, LEN_B;
  logic       GNT_A, GNT_B, VALID_A, VALID_B, DONE_A, DONE_B, BUSY;
  logic [3:0] DOUT_A, DOUT_B;
  logic [2:0] ROM_ADDR;
  logic [3:0] ROM_DATA;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  rom_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ_A(REQ_A), .REQ_B(REQ_B),
    .ADDR_A(ADDR_A), .ADDR_B(ADDR_B),
    .LEN_A(LEN_A), .LEN_B(LEN_B),
    .GNT_A(GNT_A), .GNT_B(GNT_B),
    .VALID_A(VALID_A), .VALID_B(VALID_B),
    .DOUT_A(DOUT_A), .DOUT_B(DOUT_B),
    .DONE_A(DONE_A), .DONE_B(DONE_B),
    .BUSY(BUSY),
    .ROM_ADDR(ROM_ADDR), .ROM_DATA(ROM_DATA)
  );

  logic [3:0] rom_mem [8];
  initial rom_mem = '{4'hA, 4'hB, 4'hE, 4'hA, 4'h8, 4'hF, 4'hC, 4'h9};
  always @(posedge CLK) ROM_DATA <= rom_mem[ROM_ADDR];

  // Expected words are packed with word 0 in the top nibble.
  typedef struct {
    bit          req_a, req_b;
    logic [2:0]  addr_a, len_a, addr_b, len_b;
    bit          win_a_rr, win_a_fp;
    logic [31:0] words_a, words_b;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run_vector(input int idx, input vec_t v);
    bit          win_a;
    logic [2:0]  len;
    logic [31:0] words;
    win_a = FIXED_PRIO ? v.win_a_fp : v.win_a_rr;
    len   = win_a ? v.len_a : v.len_b;
    words = win_a ? v.words_a : v.words_b;
    REQ_A = v.req_a; REQ_B = v.req_b;
    ADDR_A = v.addr_a; LEN_A = v.len_a; ADDR_B = v.addr_b; LEN_B = v.len_b;
    tick();
    check($sformatf("v%0d_gnt_a", idx), 32'(GNT_A), 32'(win_a));
    check($sformatf("v%0d_gnt_b", idx), 32'(GNT_B), 32'(!win_a));
    check($sformatf("v%0d_busy_g", idx), 32'(BUSY), 32'd1);
    // Drop requests and scramble inputs: the burst must follow the grant-edge samples.
    REQ_A = 1'b0; REQ_B = 1'b0;
    ADDR_A = ~v.addr_a; LEN_A = ~v.len_a; ADDR_B = ~v.addr_b; LEN_B = ~v.len_b;
    tick();
    check($sformatf("v%0d_g1_quiet", idx), 32'({GNT_A, GNT_B, VALID_A, VALID_B}), 32'd0);
    for (int k = 0; k <= int'(len); k++) begin
      tick();
      if (win_a) begin
        check($sformatf("v%0d_w%0d_valid", idx, k), 32'({VALID_A, VALID_B}), 32'b10);
        check($sformatf("v%0d_w%0d_dout", idx, k), 32'({DOUT_A, DOUT_B}), 32'({words[31-4*k -: 4], 4'h0}));
        check($sformatf("v%0d_w%0d_done", idx, k), 32'({DONE_A, DONE_B}), 32'({k == int'(len), 1'b0}));
      end else begin
        check($sformatf("v%0d_w%0d_valid", idx, k), 32'({VALID_A, VALID_B}), 32'b01);
        check($sformatf("v%0d_w%0d_dout", idx, k), 32'({DOUT_A, DOUT_B}), 32'({4'h0, words[31-4*k -: 4]}));
        check($sformatf("v%0d_w%0d_done", idx, k), 32'({DONE_A, DONE_B}), 32'({1'b0, k == int'(len)}));
      end
    end
    tick();
    check($sformatf("v%0d_after", idx), 32'({BUSY, VALID_A, VALID_B, DONE_A, DONE_B}), 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (BUSY && n < 30) begin
      tick();
      n++;
    end
    check(name, 32'(BUSY), 32'd0);
  endtask

  initial begin
    int         n;
    int         overlap;
    int         ngnt;
    int         gnt_edge [4];
    bit         gnt_was_a [4];
    int         edge_cnt;
    int         stray;

    //         req_a req_b addr_a len_a addr_b len_b rr  fp  words_a        words_b
    vecs[0] = '{1'b1, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b1, 32'hA000_0000, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 3'd0, 3'd0, 3'd5, 3'd4, 1'b0, 1'b0, 32'h0,         32'hFC9A_B000};
    vecs[2] = '{1'b1, 1'b1, 3'd2, 3'd1, 3'd7, 3'd2, 1'b1, 1'b1, 32'hEA00_0000, 32'h9AB0_0000};
    vecs[3] = '{1'b1, 1'b1, 3'd3, 3'd0, 3'd7, 3'd2, 1'b0, 1'b1, 32'hA000_0000, 32'h9AB0_0000};
    vecs[4] = '{1'b1, 1'b0, 3'd6, 3'd7, 3'd0, 3'd0, 1'b1, 1'b1, 32'hC9AB_EA8F, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 3'd4, 3'd2, 3'd1, 3'd3, 1'b0, 1'b1, 32'h8FC0_0000, 32'hBEA8_0000};

    RST_N = 1'b0; REQ_A = 1'b0; REQ_B = 1'b0;
    ADDR_A = 3'd0; ADDR_B = 3'd0; LEN_A = 3'd0; LEN_B = 3'd0;
    #12;
    check("reset_outputs", 32'({GNT_A, GNT_B, VALID_A, VALID_B, DOUT_A, DOUT_B, DONE_A, DONE_B, BUSY, ROM_ADDR}), 32'd0);
    #8 RST_N = 1'b1;
    tick();
    check("idle_no_req", 32'({BUSY, GNT_A, GNT_B}), 32'd0);

    for (int i = 0; i < 6; i++) run_vector(i, vecs[i]);

    // Both requesters held high: grants alternate (or stay on A with fixed priority), 4 edges apart.
    REQ_A = 1'b1; REQ_B = 1'b1; ADDR_A = 3'd0; ADDR_B = 3'd1; LEN_A = 3'd1; LEN_B = 3'd1;
    ngnt = 0; overlap = 0; edge_cnt = 0;
    while (ngnt < 4 && edge_cnt < 40) begin
      tick();
      edge_cnt++;
      if (VALID_A && VALID_B) overlap++;
      if (GNT_A || GNT_B) begin
        gnt_edge[ngnt]  = edge_cnt;
        gnt_was_a[ngnt] = GNT_A;
        ngnt++;
      end
    end
    REQ_A = 1'b0; REQ_B = 1'b0;
    check("alt_grant_count", 32'(ngnt), 32'd4);
    for (int i = 0; i < ngnt; i++)
      check($sformatf("alt_grant%0d_is_a", i), 32'(gnt_was_a[i]), 32'(FIXED_PRIO ? 1'b1 : (i % 2 == 0)));
    for (int i = 1; i < ngnt; i++)
      check($sformatf("alt_spacing%0d", i), 32'(gnt_edge[i] - gnt_edge[i-1]), 32'd4);
    check("alt_no_overlap", 32'(overlap), 32'd0);
    wait_idle("alt_drain");

    // Back-to-back: A asks while B's 3-word burst runs; grant lands exactly at G_B+3+LEN_B.
    REQ_B = 1'b1; ADDR_B = 3'd0; LEN_B = 3'd2;
    tick();
    check("b2b_gnt_b", 32'(GNT_B), 32'd1);
    REQ_B = 1'b0; REQ_A = 1'b1; ADDR_A = 3'd3; LEN_A = 3'd0;
    n = 0; overlap = 0;
    while (!GNT_A && n < 20) begin
      tick();
      n++;
      if (VALID_A && VALID_B) overlap++;
    end
    REQ_A = 1'b0;
    check("b2b_gnt_a_edge", 32'(n), 32'd5);
    check("b2b_no_overlap", 32'(overlap), 32'd0);
    tick();
    tick();
    check("b2b_a_word", 32'({VALID_A, DOUT_A, DONE_A}), 32'({1'b1, 4'hA, 1'b1}));
    wait_idle("b2b_drain");

    // Reset pulsed in the middle of an 8-word burst.
    REQ_A = 1'b1; ADDR_A = 3'd0; LEN_A = 3'd7;
    tick();
    check("rst_gnt_a", 32'(GNT_A), 32'd1);
    REQ_A = 1'b0;
    tick();
    tick();
    check("rst_first_word", 32'({VALID_A, DOUT_A}), 32'({1'b1, 4'hA}));
    tick();
    RST_N = 1'b0;
    #1;
    check("rst_mid_outputs", 32'({GNT_A, GNT_B, VALID_A, VALID_B, DOUT_A, DOUT_B, DONE_A, DONE_B, BUSY, ROM_ADDR}), 32'd0);
    #3 RST_N = 1'b1;
    stray = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (VALID_A || VALID_B || DONE_A || DONE_B || BUSY || GNT_A || GNT_B) stray++;
    end
    check("rst_no_stray", 32'(stray), 32'd0);

    // After reset LAST is B again, so A wins a tie.
    REQ_A = 1'b1; REQ_B = 1'b1; ADDR_A = 3'd5; LEN_A = 3'd0; ADDR_B = 3'd0; LEN_B = 3'd0;
    tick();
    check("rst_tie_a", 32'({GNT_A, GNT_B}), 32'b10);
    REQ_A = 1'b0; REQ_B = 1'b0;
    tick();
    tick();
    check("rst_tie_word", 32'({VALID_A, DOUT_A, DONE_A}), 32'({1'b1, 4'hF, 1'b1}));
    wait_idle("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
